coin_anim_ctrl: RTL

COIN_ANIM_CTRL -- requirements
Module: coin_anim_ctrl

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_addr_gen.sv | 43 ++++
 rtl/coin_anim_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared state type and sprite geometry for the coin animator
package coin_pkg;

  typedef enum logic [1:0] {
    ST_SPIN    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_GONE    = 2'd2
  } coin_state_t;

  localparam int SPRITE_W     = 20;
  localparam int SPRITE_H     = 20;
  localparam int SPRITE_WORDS = SPRITE_W * SPRITE_H;

endpackage

// File: rtl/coin_addr_gen.sv
// rtl/coin_addr_gen.sv - sprite hit test and frame ROM address, registered one Clk after the pixel
module coin_addr_gen
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       visible,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  input  logic [9:0] y_off,
  output logic [8:0] read_address,
  output logic       coin_on
);

  localparam int AW = $clog2(SPRITE_WORDS);

  logic [10:0]   rel_x;
  logic [10:0]   rel_y;
  logic          hit;
  logic [AW-1:0] addr;

  // 11-bit two's complement; bit 10 set means the pixel is left of / above the box
  always_comb begin
    rel_x = {1'b0, draw_x} - {1'b0, coin_x};
    rel_y = {1'b0, draw_y} - ({1'b0, coin_y} - {1'b0, y_off});
    hit   = !rel_x[10] && (rel_x[9:0] < 10'(SPRITE_W)) &&
            !rel_y[10] && (rel_y[9:0] < 10'(SPRITE_H));
    addr  = AW'(rel_y[4:0]) * AW'(SPRITE_W) + AW'(rel_x[4:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_address <= '0;
      coin_on      <= 1'b0;
    end else begin
      read_address <= hit ? addr : '0;
      coin_on      <= hit && visible;
    end
  end

endmodule

// File: rtl/coin_anim_ctrl.sv
// rtl/coin_anim_ctrl.sv - coin spin/collect/gone FSM; define COIN_POP_EN to make a collected coin rise instead of blink
module coin_anim_ctrl
  import coin_pkg::*;
#(
  parameter int SPIN_DIV      = 6,
  parameter int COLLECT_TICKS = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  input  logic       collect,
  input  logic       respawn,
  output logic [8:0] read_address,
  output logic [1:0] frame_sel,
  output logic       coin_on,
  output logic       collect_done
);

  localparam int SW = $clog2(SPIN_DIV + 1);
  localparam int CW = $clog2(COLLECT_TICKS + 1);

  coin_state_t state, state_next;
  logic [SW-1:0] spin_cnt;
  logic [CW-1:0] tick_cnt;
  logic [9:0]    y_off;
  logic          spin_last, tick_last;
  logic          visible, done_next, blink_off;

  assign spin_last = (spin_cnt == SW'(SPIN_DIV - 1));
  assign tick_last = (tick_cnt == CW'(COLLECT_TICKS - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_SPIN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SPIN:    if (collect) state_next = ST_COLLECT;
      ST_COLLECT: if (frame_tick && tick_last) state_next = ST_GONE;
      ST_GONE:    state_next = ST_GONE;
      default:    state_next = ST_SPIN;
    endcase
    if (respawn) state_next = ST_SPIN;
  end

  always_comb begin
`ifdef COIN_POP_EN
    blink_off = 1'b0;
`else
    blink_off = tick_cnt[0];
`endif
    visible   = 1'b1;
    done_next = 1'b0;
    case (state)
      ST_COLLECT: begin
        visible   = !blink_off;
        done_next = frame_tick && tick_last && !respawn;
      end
      ST_GONE: visible = 1'b0;
      default: visible = 1'b1;
    endcase
  end

  // respawn restarts the animation from frame 0 regardless of state
  always_ff @(posedge Clk) begin
    if (Reset || respawn) begin
      spin_cnt  <= '0;
      tick_cnt  <= '0;
      y_off     <= '0;
      frame_sel <= 2'd0;
    end else begin
      case (state)
        ST_SPIN: begin
          if (collect) begin
            spin_cnt <= '0;
            tick_cnt <= '0;
            y_off    <= '0;
          end else if (frame_tick) begin
            if (spin_last) begin
              spin_cnt  <= '0;
              frame_sel <= frame_sel + 2'd1;
            end else begin
              spin_cnt <= spin_cnt + SW'(1);
            end
          end
        end
        ST_COLLECT: begin
          if (frame_tick) begin
            frame_sel <= frame_sel + 2'd1;
            if (tick_last) begin
              tick_cnt <= '0;
              y_off    <= '0;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
`ifdef COIN_POP_EN
              if (y_off < 10'(COLLECT_TICKS)) y_off <= y_off + 10'd1;
`else
              y_off <= '0;
`endif
            end
          end
        end
        default: y_off <= '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) collect_done <= 1'b0;
    else       collect_done <= done_next;
  end

  coin_addr_gen u_addr (
    .clk          (Clk),
    .reset        (Reset),
    .visible      (visible),
    .draw_x       (DrawX),
    .draw_y       (DrawY),
    .coin_x       (coin_x),
    .coin_y       (coin_y),
    .y_off        (y_off),
    .read_address (read_address),
    .coin_on      (coin_on)
  );

endmodule
